// File: rtl/exec_pkg.sv
// Shared types and helpers for the Curveball execute stage.
package exec_pkg;

   // Operation select; codes 12..14 are the iterative multiply/divide ops.
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOR  = 4'd5,
      OP_SLL  = 4'd6,
      OP_SRL  = 4'd7,
      OP_SRA  = 4'd8,
      OP_SLT  = 4'd9,
      OP_SLTU = 4'd10,
      OP_LUI  = 4'd11,
      OP_MUL  = 4'd12,
      OP_DIV  = 4'd13,
      OP_DIVU = 4'd14,
      OP_NOP  = 4'd15
   } op_t;

   // Operand source; the reserved code falls back to the register file.
   typedef enum logic [1:0] {
      FWD_REG   = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2,
      FWD_RSVD  = 2'd3
   } fwd_t;

   // Flag update mode.
   typedef enum logic [1:0] {
      FLAG_HOLD = 2'd0,
      FLAG_EQ   = 2'd1,
      FLAG_LT   = 2'd2,
      FLAG_LTU  = 2'd3
   } flag_t;

   // Multiply/divide sequencer states.
   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   // True for operations handled by the iterative unit.
   function automatic logic is_multicycle(input op_t op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative radix-2 multiply (shift-add) and restoring divide unit.
// One step per cycle for WIDTH cycles; results land in lo/hi registers
// on the final BUSY edge and are held until the next completed operation.
module md_unit
   import exec_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             kill,
   input  op_t              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output md_state_t        state,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   op_t              op_q;
   // acc: product high half / partial remainder.
   // sh:  multiplier shifting out / dividend shifting out, quotient shifting in.
   // opnd: multiplicand / divisor magnitude.
   logic [WIDTH-1:0] acc_q, sh_q, opnd_q;
   logic [WIDTH-1:0] dvd_q;
   logic             neg_quo_q, neg_rem_q, div_zero_q;
   logic [WIDTH-1:0] lo_q, hi_q;

   logic [WIDTH-1:0] step_acc, step_sh;
   logic [WIDTH:0]   mul_sum, div_shift, div_trial;
   logic             div_ge;
   logic [WIDTH-1:0] fin_lo, fin_hi;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign busy  = (state_q == MD_BUSY);
   assign done  = (state_q == MD_DONE);
   assign state = state_q;
   assign lo    = lo_q;
   assign hi    = hi_q;

   // Operand magnitudes and signs captured at issue (signed DIV only).
   always_comb begin
      a_neg = (op == OP_DIV) && a[WIDTH-1];
      b_neg = (op == OP_DIV) && b[WIDTH-1];
      a_mag = a_neg ? (~a + 1'b1) : a;
      b_mag = b_neg ? (~b + 1'b1) : b;
   end

   // One radix-2 step of the selected operation plus the final correction.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {acc_q, sh_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd_q};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      step_acc  = '0;
      step_sh   = '0;
      fin_lo    = '0;
      fin_hi    = '0;
      if (op_q == OP_MUL) begin
         step_acc = mul_sum[WIDTH:1];
         step_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
         fin_lo   = step_sh;
         fin_hi   = step_acc;
      end else begin
         // Partial remainder stays below the divisor, so WIDTH bits suffice.
         step_acc = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
         step_sh  = {sh_q[WIDTH-2:0], div_ge};
         if (div_zero_q) begin
            fin_lo = '1;
            fin_hi = dvd_q;
         end else begin
            fin_lo = neg_quo_q ? (~step_sh + 1'b1) : step_sh;
            fin_hi = neg_rem_q ? (~step_acc + 1'b1) : step_acc;
         end
      end
   end

   // Next-state logic; kill wins from any state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (start) state_d = MD_BUSY;
         MD_BUSY: if (cnt_q == '0) state_d = MD_DONE;
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
      if (kill) state_d = MD_IDLE;
   end

   // State, working registers and result registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= MD_IDLE;
         cnt_q      <= '0;
         op_q       <= OP_NOP;
         acc_q      <= '0;
         sh_q       <= '0;
         opnd_q     <= '0;
         dvd_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == MD_IDLE && start && !kill) begin
            op_q       <= op;
            cnt_q      <= CNT_W'(WIDTH - 1);
            acc_q      <= '0;
            dvd_q      <= a;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= (b == '0);
            if (op == OP_MUL) begin
               sh_q   <= b;
               opnd_q <= a;
            end else begin
               sh_q   <= a_mag;
               opnd_q <= b_mag;
            end
         end else if (state_q == MD_BUSY && !kill) begin
            acc_q <= step_acc;
            sh_q  <= step_sh;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
               lo_q <= fin_lo;
               hi_q <= fin_hi;
            end
         end
      end
   end

endmodule

// File: rtl/exec_stage_p.sv
// Execute stage: operand forwarding, single-cycle ALU, condition flag and
// an iterative multiply/divide unit that stalls the pipeline while busy.
module exec_stage_p
   import exec_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic             flush,
   input  op_t              op,
   input  logic [1:0]       fwd_a,
   input  logic [1:0]       fwd_b,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic [WIDTH-1:0] fwd_exmem,
   input  logic [WIDTH-1:0] fwd_memwb,
   input  logic [1:0]       set_flag,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] hi_rem,
   output logic             flag,
   output logic             stall,
   output logic [WIDTH-1:0] rs_pass
);

   logic [WIDTH-1:0] opnd_a, opnd_b, alu_res;
   logic [CNT_W-1:0] shamt;
   logic             mc_op, md_start, md_busy, md_done, md_idle, flag_en;
   md_state_t        md_state;
   logic [WIDTH-1:0] md_lo, md_hi;

   assign rs_pass = rs_data;
   assign shamt   = opnd_b[CNT_W-1:0];
   assign mc_op   = is_multicycle(op);
   assign md_idle = (md_state == MD_IDLE);
   // The unit only accepts a start while idle; flush is applied as kill.
   assign md_start = valid && mc_op;
   // Depends only on state, valid, op and flush, never on alu_out.
   assign stall   = rst && !flush && (md_busy || (md_idle && valid && mc_op));
   assign flag_en = valid && !flush && !stall && (flag_t'(set_flag) != FLAG_HOLD);
   assign hi_rem  = md_hi;
   assign alu_out = !rst ? '0 : (md_done ? md_lo : alu_res);

   // Forwarding muxes for both operands.
   always_comb begin
      case (fwd_t'(fwd_a))
         FWD_EXMEM: opnd_a = fwd_exmem;
         FWD_MEMWB: opnd_a = fwd_memwb;
         default:   opnd_a = rs_data;
      endcase
      case (fwd_t'(fwd_b))
         FWD_EXMEM: opnd_b = fwd_exmem;
         FWD_MEMWB: opnd_b = fwd_memwb;
         default:   opnd_b = rt_data;
      endcase
   end

   // Single-cycle ALU; multi-cycle ops produce zero here.
   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = opnd_a + opnd_b;
         OP_SUB:  alu_res = opnd_a - opnd_b;
         OP_AND:  alu_res = opnd_a & opnd_b;
         OP_OR:   alu_res = opnd_a | opnd_b;
         OP_XOR:  alu_res = opnd_a ^ opnd_b;
         OP_NOR:  alu_res = ~(opnd_a | opnd_b);
         OP_SLL:  alu_res = opnd_a << shamt;
         OP_SRL:  alu_res = opnd_a >> shamt;
         OP_SRA:  alu_res = WIDTH'($signed(opnd_a) >>> shamt);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(opnd_a) < $signed(opnd_b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (opnd_a < opnd_b)};
         OP_LUI:  alu_res = opnd_b << (WIDTH / 2);
         default: alu_res = '0;
      endcase
   end

   // Condition flag register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         flag <= 1'b0;
      end else if (flag_en) begin
         case (flag_t'(set_flag))
            FLAG_EQ:  flag <= (opnd_a == opnd_b);
            FLAG_LT:  flag <= ($signed(opnd_a) < $signed(opnd_b));
            FLAG_LTU: flag <= (opnd_a < opnd_b);
            default:  flag <= flag;
         endcase
      end
   end

   md_unit #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_md (
      .clk   (clk),
      .rst   (rst),
      .start (md_start),
      .kill  (flush),
      .op    (op),
      .a     (opnd_a),
      .b     (opnd_b),
      .busy  (md_busy),
      .done  (md_done),
      .state (md_state),
      .lo    (md_lo),
      .hi    (md_hi)
   );

endmodule

// File: tb/tb_exec_stage_p.sv
// Directed bench for exec_stage_p (WIDTH=16) with an expected-result queue.
// Handshake: an instruction leaves EX on a cycle where rst && valid && !flush
// && !stall; the monitor pops one expected entry for each such cycle.
module tb_exec_stage_p;
   import exec_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst, valid, flush;
   op_t          op;
   logic [1:0]   fwd_a, fwd_b, set_flag;
   logic [W-1:0] rs_data, rt_data, fwd_exmem, fwd_memwb;
   logic [W-1:0] alu_out, hi_rem, rs_pass;
   logic         flag, stall;

   typedef struct {
      int         id;
      logic [W-1:0] alu;
      logic       chk_hi;
      logic [W-1:0] hi;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   exec_stage_p #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .flush     (flush),
      .op        (op),
      .fwd_a     (fwd_a),
      .fwd_b     (fwd_b),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .fwd_exmem (fwd_exmem),
      .fwd_memwb (fwd_memwb),
      .set_flag  (set_flag),
      .alu_out   (alu_out),
      .hi_rem    (hi_rem),
      .flag      (flag),
      .stall     (stall),
      .rs_pass   (rs_pass)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Monitor: compare each instruction leaving EX with the queue head.
   always @(negedge clk) begin
      if (rst && valid && !flush && !stall) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result act=%h exp=none", alu_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("alu_out_id%0d", e.id), alu_out, e.alu);
            if (e.chk_hi) chk($sformatf("hi_rem_id%0d", e.id), hi_rem, e.hi);
            chk($sformatf("rs_pass_id%0d", e.id), rs_pass, rs_data);
         end
      end
   end

   // Driver: present one instruction, push its expectation, count stall cycles.
   // Called at posedge+1; returns at posedge+1 after the instruction leaves EX.
   task automatic issue(input int id, input op_t o, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [W-1:0] rs, input logic [W-1:0] rt,
                        input logic [W-1:0] ex, input logic [W-1:0] mw, input logic [1:0] sf,
                        input logic [W-1:0] e_alu, input logic e_chk_hi,
                        input logic [W-1:0] e_hi, input int e_stall);
      exp_t e;
      int   n;
      op = o; fwd_a = fa; fwd_b = fb; rs_data = rs; rt_data = rt;
      fwd_exmem = ex; fwd_memwb = mw; set_flag = sf; valid = 1'b1; flush = 1'b0;
      e.id = id; e.alu = e_alu; e.chk_hi = e_chk_hi; e.hi = e_hi;
      exp_q.push_back(e);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (stall) n++;
         else break;
      end
      checks++;
      if (n != e_stall) begin
         failures++;
         $display("FAIL stall_cycles_id%0d act=%0d exp=%0d", id, n, e_stall);
      end
      @(posedge clk);
      #1;
   endtask

   // Stimulus sequence.
   initial begin
      rst = 1'b0; valid = 1'b0; flush = 1'b0; op = OP_ADD;
      fwd_a = 2'd0; fwd_b = 2'd0; set_flag = 2'd0;
      rs_data = 16'h0; rt_data = 16'h0; fwd_exmem = 16'h0; fwd_memwb = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_stall", {15'b0, stall}, 16'h0000);
      chk("reset_alu_out", alu_out, 16'h0000);
      chk("reset_hi_rem", hi_rem, 16'h0000);
      chk("reset_flag", {15'b0, flag}, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b1;

      // Single-cycle ops with forwarding.
      issue(1, OP_ADD,  2'd1, 2'd0, 16'h9999, 16'h0004, 16'h0003, 16'h0000, 2'd0, 16'h0007, 1'b0, 16'h0, 0);
      issue(2, OP_XOR,  2'd0, 2'd0, 16'hF0F0, 16'h0FF0, 16'h0000, 16'h0000, 2'd0, 16'hFF00, 1'b0, 16'h0, 0);
      issue(3, OP_SRA,  2'd0, 2'd0, 16'h8000, 16'h0014, 16'h0000, 16'h0000, 2'd0, 16'hF800, 1'b0, 16'h0, 0);
      issue(4, OP_SLTU, 2'd2, 2'd0, 16'h7777, 16'hFFFF, 16'h0000, 16'h0001, 2'd0, 16'h0001, 1'b0, 16'h0, 0);
      issue(5, OP_LUI,  2'd0, 2'd0, 16'h0000, 16'h00AB, 16'h0000, 16'h0000, 2'd0, 16'hAB00, 1'b0, 16'h0, 0);

      // Multi-cycle ops: 17 stall cycles each, results in the DONE cycle.
      issue(6,  OP_DIV,  2'd0, 2'd0, 16'hFFF9, 16'h0002, 16'h0000, 16'h0000, 2'd0, 16'hFFFD, 1'b1, 16'hFFFF, 17);
      issue(7,  OP_DIVU, 2'd1, 2'd2, 16'h0000, 16'h5555, 16'h1234, 16'h0000, 2'd0, 16'hFFFF, 1'b1, 16'h1234, 17);
      issue(8,  OP_DIV,  2'd3, 2'd0, 16'h8000, 16'hFFFF, 16'h1111, 16'h2222, 2'd0, 16'h8000, 1'b1, 16'h0000, 17);
      issue(9,  OP_MUL,  2'd0, 2'd0, 16'h0100, 16'h0300, 16'h0000, 16'h0000, 2'd0, 16'h0000, 1'b1, 16'h0003, 17);
      issue(10, OP_MUL,  2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 2'd0, 16'h0001, 1'b1, 16'hFFFE, 17);

      // Flush in the 6th BUSY cycle of a DIV.
      op = OP_DIV; fwd_a = 2'd0; fwd_b = 2'd0; rs_data = 16'hFFF9; rt_data = 16'h0002;
      set_flag = 2'd0; valid = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", {15'b0, stall}, 16'h0000);
      @(posedge clk); #1;
      issue(11, OP_SUB, 2'd2, 2'd1, 16'h0000, 16'h0000, 16'h0007, 16'h0005, 2'd0, 16'hFFFE, 1'b1, 16'hFFFE, 0);

      // Flag set by equality, then held across a bubble.
      issue(12, OP_ADD, 2'd0, 2'd0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 2'd1, 16'h000A, 1'b0, 16'h0, 0);
      chk("flag_eq", {15'b0, flag}, 16'h0001);
      valid = 1'b0; set_flag = 2'd1; rs_data = 16'h0001; rt_data = 16'h0002;
      @(posedge clk); #1;
      chk("flag_bubble_hold", {15'b0, flag}, 16'h0001);

      // Reset while BUSY.
      op = OP_DIV; rs_data = 16'h1234; rt_data = 16'h0003; set_flag = 2'd0; valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy_stall", {15'b0, stall}, 16'h0000);
      chk("rst_busy_alu_out", alu_out, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b1; valid = 1'b0;
      @(negedge clk);
      chk("post_rst_flag", {15'b0, flag}, 16'h0000);
      chk("post_rst_hi_rem", hi_rem, 16'h0000);
      chk("post_rst_stall", {15'b0, stall}, 16'h0000);
      @(posedge clk); #1;

      // Signed vs unsigned compare flags.
      issue(13, OP_ADD, 2'd0, 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'd2, 16'h0000, 1'b0, 16'h0, 0);
      chk("flag_lt_signed", {15'b0, flag}, 16'h0001);
      issue(14, OP_ADD, 2'd0, 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'd3, 16'h0000, 1'b0, 16'h0, 0);
      chk("flag_ltu", {15'b0, flag}, 16'h0000);

      valid = 1'b0; set_flag = 2'd0;
      repeat (3) @(posedge clk);
      chk("queue_empty", W'(exp_q.size()), 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_stage_p.md
# exec_stage_p

Parametrised execute stage for the Curveball pipeline: operand forwarding, single-cycle ALU, flag register, and an iterative multiply/divide unit that stalls the pipeline while it runs. It sits between the register-read/decode latch and the EX/MEM latch, and generalises the fixed 16-bit execute stage with these additions:
- width-parametrised datapath;
- three-way forwarding;
- hardware multiply;
- defined divide-by-zero behaviour;
- flush abort.

## Interface
Parameters:
- WIDTH, 16, datapath width; must be ≥4 and even.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- valid  in  1  the instruction in EX is real (not a bubble).
- flush  in  1  kill the instruction in EX; aborts any mul/div.
- op  in  4  operation select (exec_pkg::op_t).
- fwd_a, fwd_b  in  2  operand source: 0 = reg file, 1 = EX/MEM, 2 = MEM/WB, 3 = reserved (selects reg file).
- rs_data, rt_data  in  WIDTH  register-file operands.
- fwd_exmem, fwd_memwb  in  WIDTH  forwarding buses.
- set_flag  in  2  0 = hold, 1 = flag←(A==B), 2 = flag←(A<B signed), 3 = flag←(A<B unsigned).
- alu_out  out  WIDTH  result (quotient for divides, low half for MUL).
- hi_rem  out  WIDTH  remainder (DIV/DIVU) or high half (MUL); registered.
- flag  out  1  condition flag; registered.
- stall  out  1  hold upstream stages and insert a bubble into EX/MEM.
- rs_pass  out  WIDTH  unforwarded rs_data, passed through for store/jump use.

## Operation
Operands:
- A = mux(fwd_a), B = mux(fwd_b), both combinational.

Single-cycle ops (ADD, SUB, AND, OR, XOR, NOR, SLL, SRL, SRA, SLT, SLTU, LUI):
- alu_out is combinational in the same cycle.
- Shift amount is B[CNT_W-1:0].
- Arithmetic wraps modulo 2^WIDTH.

Flag:
- flag updates on the edge when valid & !flush & !stall & set_flag≠0.

Multi-cycle ops (MUL, DIV, DIVU), FSM states IDLE, BUSY, DONE:
- **IDLE:**
  - On valid & !flush & multi-cycle op: stall=1, latch A, B and op.
  - For DIV, latch operand magnitudes and result signs.
  - Load cnt=WIDTH-1 and go to BUSY.
- **BUSY:** stall=1.
  - One radix-2 step per cycle: shift-add for MUL, restoring shift-subtract for DIV/DIVU.
  - cnt decrements; when cnt==0, the next state is DONE.
- **DONE:**
  - stall=0; alu_out and hi_rem driven from result registers.
  - Apply sign correction for DIV: quotient negative iff signs differ; remainder takes the dividend's sign.
  - Next edge returns to IDLE. The upstream latch advances on that edge because stall is low, so the same instruction is not reissued.

MUL:
- Unsigned WIDTH×WIDTH → 2·WIDTH.
- Low half goes to alu_out, high half to hi_rem.

Divide by zero:
- Quotient is all ones; remainder is the dividend.
- No exception is raised.

Signed overflow:
- DIV of MIN by −1 gives quotient MIN, remainder 0.

Flush:
- flush in any state: stall=0 that cycle, FSM→IDLE on the next edge.
- Result registers and flag are not updated.
- flush has priority over valid.

Bubbles:
- valid=0 in IDLE: stall=0, no state change, alu_out still computed, flag held.

## Timing
- Single-cycle op latency: 0 cycles (combinational through EX), captured by the EX/MEM latch on the next edge.
- MUL/DIV/DIVU:
  - stall is high for exactly WIDTH+1 consecutive cycles: 1 issue cycle plus WIDTH BUSY cycles.
  - The result is valid in the DONE cycle (cycle WIDTH+1 after issue) and is captured at the end of it.
  - Back-to-back multi-cycle ops: the second issues in the cycle after DONE. No overlap.
- Reset:
  - While rst=0, the next edge sets FSM=IDLE, cnt=0, flag=0, hi_rem=0 and the result registers to 0.
  - stall is forced 0 and alu_out is forced 0 while rst=0.
  - Reset mid-BUSY discards the operation.
- stall is combinational from the state and from valid/op/flush. It has no dependence on alu_out, so no loop forms through forwarding.

## Structure
Package exec_pkg holds:
- op_t (4-bit enum);
- fwd_t (REG, EXMEM, MEMWB);
- flag_t (HOLD, EQ, LT, LTU);
- md_state_t (IDLE, BUSY, DONE);
- the is_multicycle(op_t) function.

Sub-module md_unit (parameter WIDTH):
- Contains the FSM, counter and shift datapath for mul/div.
- Ports: start, kill, op, a, b → busy, done, lo, hi.

exec_stage_p holds the forwarding muxes, combinational ALU and flag register, and instantiates md_unit.

## Test plan
All scenarios use WIDTH=16.
- ADD with fwd_a=1, fwd_exmem=0x0003, rs_data=0x9999, rt_data=0x0004 → alu_out=0x0007 same cycle, stall=0.
- DIV with A=0xFFF9 (−7), B=0x0002 → stall high 17 cycles; DONE cycle gives alu_out=0xFFFD, hi_rem=0xFFFF.
- DIVU with A=0x1234, B=0x0000 → after 17 stall cycles, alu_out=0xFFFF and hi_rem=0x1234. DIV with A=0x8000, B=0xFFFF → alu_out=0x8000, hi_rem=0x0000.
- MUL with A=0x0100, B=0x0300 → alu_out=0x0000, hi_rem=0x0003; then an immediate second MUL, 0xFFFF×0xFFFF → alu_out=0x0001, hi_rem=0xFFFE.
- flush pulsed in the 6th BUSY cycle of a DIV → stall=0 that cycle and IDLE next; a following SUB of 5−7 → alu_out=0xFFFE with stall=0; hi_rem unchanged.
- rst=0 during BUSY, with flag previously 1 → after the edge, stall=0, flag=0, hi_rem=0. With set_flag=2, A=0xFFFF, B=0x0001 → flag=1; with set_flag=3 → flag=0.
